// File: rtl/hls_fp17_to_fp16_pkg.sv
// Shared parameters and helpers for the fp17-to-fp16 output channel buffer.
package hls_fp17_to_fp16_pkg;

    localparam int DATA_W      = 16;
    localparam int BUF_DEPTH   = 2;
    localparam int STALL_CNT_W = 16;

    // Pointer and occupancy widths derived from the two-entry depth
    localparam int PTR_W = 1;
    localparam int CNT_W = 2;

    localparam logic [CNT_W-1:0] COUNT_EMPTY = 2'd0;
    localparam logic [CNT_W-1:0] COUNT_FULL  = 2'd2;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_ONE = STALL_CNT_W'(1);

    typedef logic [DATA_W-1:0] data_t;

    // Occupancy after one cycle of push/pop activity
    function automatic logic [CNT_W-1:0] nextCount(
        input logic [CNT_W-1:0] count,
        input logic             push,
        input logic             pop
    );
        logic [CNT_W-1:0] result;
        result = count;
        if (push && !pop) begin
            result = count + 2'd1;
        end else if (!push && pop) begin
            result = count - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hls_fp17_to_fp16_ofifo2.sv
// Two-entry storage array with wrapping write/read pointers.
// Occupancy tracking lives in the parent; this block only stores and addresses.
module hls_fp17_to_fp16_ofifo2
    import hls_fp17_to_fp16_pkg::*;
(
    input  logic  clk_i,
    input  logic  rstn_i,
    input  logic  push_i,
    input  logic  pop_i,
    input  data_t wdata_i,
    output data_t rdata_o
);

    data_t             mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W-1:0]  wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [PTR_W-1:0]  rdPtr_d;

    // Pointers advance by one on their own operation and wrap naturally at the 1-bit width
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (push_i) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop_i) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    // Storage and pointer registers; reset clears every entry so stale data cannot resurface
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= wdata_i;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    assign rdata_o = mem_q[rdPtr_q];

endmodule

// File: rtl/hls_fp17_to_fp16_chn_o_buf.sv
// Output channel buffer between the fp17->fp16 core and the downstream consumer.
// Holds up to two results, reports space to the staller, counts stall cycles
// and flags any result lost because the buffer was full.
module hls_fp17_to_fp16_chn_o_buf
    import hls_fp17_to_fp16_pkg::*;
(
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic                   core_wen,
    input  logic                   core_wten,
    input  logic                   chn_o_core_vld,
    input  logic [DATA_W-1:0]      chn_o_core_z,
    output logic                   chn_o_rsci_wen_comp,
    output logic [DATA_W-1:0]      chn_o_rsc_z,
    output logic                   chn_o_rsc_lz,
    input  logic                   chn_o_rsc_vz,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   ovf_err
);

    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   wenComp_q;
    logic                   wenComp_d;
    logic [STALL_CNT_W-1:0] stallCnt_q;
    logic [STALL_CNT_W-1:0] stallCnt_d;
    logic                   ovfErr_q;
    logic                   ovfErr_d;

    logic                   pushReq;
    logic                   isFull;
    logic                   push;
    logic                   pop;
    data_t                  headData;

    assign pushReq = core_wen & chn_o_core_vld;
    assign isFull  = (count_q == COUNT_FULL);
    assign push    = pushReq & ~isFull;
    assign pop     = chn_o_rsc_lz & chn_o_rsc_vz;

    hls_fp17_to_fp16_ofifo2 uFifo (
        .clk_i   (nvdla_core_clk),
        .rstn_i  (nvdla_core_rstn),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (chn_o_core_z),
        .rdata_o (headData)
    );

    // Next-state for occupancy, space flag, stall counter and overflow flag
    always_comb begin
        count_d    = nextCount(count_q, push, pop);
        wenComp_d  = (count_d != COUNT_FULL);
        stallCnt_d = stallCnt_q;
        if (core_wten && (stallCnt_q != STALL_CNT_MAX)) begin
            stallCnt_d = stallCnt_q + STALL_CNT_ONE;
        end
        ovfErr_d = ovfErr_q | (pushReq & isFull);
    end

    // Control registers; space flag stays low during reset so the core cannot write into a cleared buffer
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            count_q    <= COUNT_EMPTY;
            wenComp_q  <= 1'b0;
            stallCnt_q <= '0;
            ovfErr_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            wenComp_q  <= wenComp_d;
            stallCnt_q <= stallCnt_d;
            ovfErr_q   <= ovfErr_d;
        end
    end

    assign chn_o_rsci_wen_comp = wenComp_q;
    assign chn_o_rsc_lz        = (count_q != COUNT_EMPTY);
    assign chn_o_rsc_z         = chn_o_rsc_lz ? headData : '0;
    assign stall_cnt           = stallCnt_q;
    assign ovf_err             = ovfErr_q;

endmodule

// File: tb/tb_hls_fp17_to_fp16_chn_o_buf.sv
// Self-checking bench for the output channel buffer: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_hls_fp17_to_fp16_chn_o_buf;

    logic        clk;
    logic        rstn;
    logic        coreWen;
    logic        coreWten;
    logic        coreVld;
    logic [15:0] coreZ;
    logic        wenComp;
    logic [15:0] rscZ;
    logic        rscLz;
    logic        rscVz;
    logic [15:0] stallCnt;
    logic        ovfErr;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state
    logic [15:0] modelQ[$];
    int          modelStall;
    bit          modelOvf;
    bit          modelWen;

    hls_fp17_to_fp16_chn_o_buf dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rstn     (rstn),
        .core_wen            (coreWen),
        .core_wten           (coreWten),
        .chn_o_core_vld      (coreVld),
        .chn_o_core_z        (coreZ),
        .chn_o_rsci_wen_comp (wenComp),
        .chn_o_rsc_z         (rscZ),
        .chn_o_rsc_lz        (rscLz),
        .chn_o_rsc_vz        (rscVz),
        .stall_cnt           (stallCnt),
        .ovf_err             (ovfErr)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it when it does not match
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare every DUT output against the model
    task automatic compareAll();
        logic [15:0] expZ;
        expZ = (modelQ.size() != 0) ? modelQ[0] : 16'h0000;
        checkOutput("lz", {31'd0, rscLz}, {31'd0, modelQ.size() != 0});
        checkOutput("z", {16'd0, rscZ}, {16'd0, expZ});
        checkOutput("wenComp", {31'd0, wenComp}, {31'd0, modelWen});
        checkOutput("ovfErr", {31'd0, ovfErr}, {31'd0, modelOvf});
        checkOutput("stallCnt", {16'd0, stallCnt}, modelStall);
    endtask

    // Drive one cycle of inputs, advance the model, clock the DUT and optionally compare
    task automatic applyStimulus(input bit rIn, input bit wen, input bit wten, input bit vld,
                                 input logic [15:0] din, input bit vz, input bit chk);
        bit doPop;
        bit full;
        rstn     = rIn;
        coreWen  = wen;
        coreWten = wten;
        coreVld  = vld;
        coreZ    = din;
        rscVz    = vz;
        if (!rIn) begin
            modelQ.delete();
            modelStall = 0;
            modelOvf   = 0;
            modelWen   = 0;
        end else begin
            doPop = (modelQ.size() != 0) && vz;
            full  = (modelQ.size() == 2);
            if (wen && vld && full) modelOvf = 1;
            if (doPop) void'(modelQ.pop_front());
            if (wen && vld && !full) modelQ.push_back(din);
            modelWen = (modelQ.size() != 2);
            if (wten && modelStall < 65535) modelStall++;
        end
        @(posedge clk);
        #1;
        if (chk) compareAll();
    endtask

    logic [15:0] streamVals [8];

    // Test sequence
    initial begin
        rstn = 1'b0; coreWen = 1'b0; coreWten = 1'b0; coreVld = 1'b0; coreZ = '0; rscVz = 1'b0;
        modelStall = 0; modelOvf = 0; modelWen = 0;

        // Reset for three cycles, all outputs low
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 16'h0, 0, 1);
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 1);
        checkOutput("wenAfterRst", {31'd0, wenComp}, 32'd1);
        checkOutput("lzAfterRst", {31'd0, rscLz}, 32'd0);

        // Single push visible one cycle later
        applyStimulus(1, 1, 0, 1, 16'h3C00, 0, 1);
        checkOutput("singleLz", {31'd0, rscLz}, 32'd1);
        checkOutput("singleZ", {16'd0, rscZ}, 32'h3C00);
        checkOutput("singleWen", {31'd0, wenComp}, 32'd1);

        // Fill to two, then overflow
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 1);
        applyStimulus(1, 1, 0, 1, 16'h0001, 0, 1);
        applyStimulus(1, 1, 0, 1, 16'h0002, 0, 1);
        checkOutput("fullWen", {31'd0, wenComp}, 32'd0);
        applyStimulus(1, 1, 0, 1, 16'h0003, 0, 1);
        checkOutput("ovfSet", {31'd0, ovfErr}, 32'd1);
        checkOutput("ovfHeadZ", {16'd0, rscZ}, 32'h0001);
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 1);
        checkOutput("ovfSticky", {31'd0, ovfErr}, 32'd1);

        // Reset while full discards the contents
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 1);
        checkOutput("rstFullLz", {31'd0, rscLz}, 32'd0);
        applyStimulus(1, 0, 0, 0, 16'h0, 1, 1);
        checkOutput("rstFullZ", {16'd0, rscZ}, 32'h0000);
        checkOutput("rstFullOvf", {31'd0, ovfErr}, 32'd0);

        // Streaming at full throughput
        for (int i = 0; i < 8; i++) streamVals[i] = 16'(16'h4000 + i * 16'h0111);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 0, 1, streamVals[i], 1, 1);
            checkOutput("streamZ", {16'd0, rscZ}, {16'd0, streamVals[i]});
            checkOutput("streamWen", {31'd0, wenComp}, 32'd1);
        end
        applyStimulus(1, 0, 0, 0, 16'h0, 1, 1);
        checkOutput("streamDrained", {31'd0, rscLz}, 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                          16'($urandom), $urandom_range(0, 2) != 0, 1);
        end

        // Long stall run to reach saturation
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 1);
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(1, 0, 1, 0, 16'h0, 0, (i % 4096) == 0 || i > 65530);
        end
        checkOutput("stallSat", {16'd0, stallCnt}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
